// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls on load-use, flushes on redirect, freezes on memory wait, halts on syscall.
// Latency: enables and flushes are combinational from state and inputs, and the state and counters are registered.
// Backpressure: mem_ready low freezes the whole pipe, and halt freezes everything until resume.
module hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_memtoreg,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             halt_blk_q, halt_blk_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic halt_eff;
    logic stall_inc;
    logic flush_inc;

    // Load-use hazard: the EX load targets a non-zero register that ID actually reads.
    always_comb begin
        lu = ex_memtoreg && ex_regwrite && (ex_rd != '0) &&
             ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    end

    // A halt_req still held from the resume cycle must not re-enter HALT until it drops.
    always_comb begin
        halt_eff = halt_req && !halt_blk_q;
    end

    // Prioritised output decode (halt > memory freeze > redirect > load-use > run) and next state.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_en    = 1'b1;
        halted     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        state_d    = state_q;
        halt_blk_d = halt_blk_q;

        if (!halt_req) begin
            halt_blk_d = 1'b0;
        end

        if (!rst) begin
            state_d    = RUN;
            halt_blk_d = 1'b0;
        end else if (state_q == HALT) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
            halted  = 1'b1;
            if (resume) begin
                state_d    = RUN;
                halt_blk_d = halt_req;
            end
        end else if (halt_eff) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
            halted  = 1'b1;
            state_d = HALT;
        end else if (!mem_ready) begin
            // EX/ID are frozen, so redirect and lu are re-evaluated once memory is ready.
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
            state_d = MEM_WAIT;
        end else begin
            state_d = RUN;
            if (ex_redirect) begin
                // The dependent instruction in ID is squashed, so the redirect overrides lu.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flush_inc  = 1'b1;
            end else if (lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                stall_inc  = 1'b1;
            end
        end
    end

    // Saturating event counters, where a clear beats an increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // State, halt re-entry guard and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            halt_blk_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_blk_q  <= halt_blk_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counter outputs.
    always_comb begin
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU. Generates the enable and flush controls for the PC, the IF/ID stage register and the later stage registers.
- Resolves four conditions:
  - load-use stalls,
  - taken-branch/jump redirects (flush),
  - multi-cycle data-memory waits (global freeze),
  - syscall halt.
- Keeps saturating stall and flush event counters for the debug display.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- id_rs  in  REG_W  rs index of the instruction in ID.
- id_rt  in  REG_W  rt index of the instruction in ID.
- id_use_rs  in  1  the ID instruction reads rs.
- id_use_rt  in  1  the ID instruction reads rt.
- ex_memtoreg  in  1  the EX instruction is a load.
- ex_regwrite  in  1  the EX instruction writes a register.
- ex_rd  in  REG_W  destination index of the EX instruction.
- ex_redirect  in  1  branch/jump/jr taken, resolved in EX.
- mem_ready  in  1  data memory done; low means wait.
- halt_req  in  1  syscall halt, from WB.
- resume  in  1  single-cycle go pulse from the board button (already synchronised).
- clr_cnt  in  1  synchronous counter clear.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a bubble (all control signals 0).
- pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- halted  out  1  high while in HALT.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  redirect events.

Behaviour:
- State register with three states: RUN, MEM_WAIT, HALT.
  - Async reset (rst=0) forces RUN and clears both counters.
  - Outputs are combinational from state and inputs.
- Reset-time output values (rst=0 or state RUN with all inputs 0):
  - pc_en=1, ifid_en=1, pipe_en=1.
  - ifid_flush=0, idex_flush=0, halted=0.
  - stall_cnt=0, flush_cnt=0.
- Load-use hazard term: lu = ex_memtoreg & ex_regwrite & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Output priority per cycle, highest first:
  1. HALT state, or halt_req in RUN/MEM_WAIT:
     - pc_en=0, ifid_en=0, pipe_en=0, flushes=0, halted=1.
     - halted=1 in the same cycle as halt_req.
     - Next state HALT.
  2. MEM_WAIT state, or mem_ready=0 in RUN:
     - pc_en=0, ifid_en=0, pipe_en=0, flushes=0.
     - Redirect and lu are ignored this cycle and re-evaluated later, because the EX/ID contents are frozen.
  3. ex_redirect:
     - pc_en=1 (PC takes the target), ifid_flush=1, idex_flush=1, pipe_en=1.
     - Overrides lu, since the dependent instruction is squashed.
     - flush_cnt increments.
  4. lu:
     - pc_en=0, ifid_en=0, idex_flush=1, pipe_en=1.
     - Exactly one bubble: next cycle the load has moved to MEM and lu drops.
     - stall_cnt increments.
  5. Otherwise: normal run values.
- State transitions:
  - RUN -> MEM_WAIT when mem_ready=0 (and no halt_req).
  - MEM_WAIT -> RUN on the first cycle mem_ready=1. That cycle already evaluates rows 3-5.
  - RUN or MEM_WAIT -> HALT on halt_req.
  - HALT -> RUN on resume.
  - In HALT, halt_req is ignored and resume wins. If halt_req and resume arrive together, leave HALT and do not re-enter until a new halt_req arrives with resume low.
- Counters:
  - Saturate at all-ones and do not wrap.
  - clr_cnt has priority over increment and takes effect at the next edge.
  - Counters do not increment in HALT or MEM_WAIT.
- Reset asserted mid-stall or mid-halt returns to RUN immediately and asynchronously. Outputs take their reset values without waiting for a clock edge.

Test Plan:
- Load-use: EX holds lw to $8, ID reads rs=$8 with id_use_rs=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt goes 0->1; the following cycle has all run values.
- Load to $0 or with id_use_rs=0: ex_rd=0, id_rs=0 -> no stall; stall_cnt stays 0.
- Redirect with lu in the same cycle: ex_redirect=1 and lu=1 -> pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1; stall_cnt=0.
- Memory wait: mem_ready=0 for 3 cycles with ex_redirect=1 -> pc_en=0 and pipe_en=0 for 3 cycles, then one flush cycle when mem_ready=1; flush_cnt increments once.
- Halt/resume: pulse halt_req -> halted=1 and all enables 0 until resume; halt_req held together with resume -> returns to RUN; async rst=0 during HALT -> halted=0 immediately.
- Saturation/clear: force 65535 stalls -> stall_cnt=0xFFFF and holds; clr_cnt together with lu -> stall_cnt=0 next cycle.
